// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the E-stage divide sequencer: FSM state encoding,
// iteration count, divide-by-zero quotient and {hi, lo} result field layout.
// Ports: none (package).
package div_seq_ctrl_pkg;

  // Default operand width; one quotient bit is produced per DIV cycle.
  localparam int DIV_WIDTH  = 32;
  localparam int DIV_CYCLES = DIV_WIDTH;

  // Quotient reported for a zero divisor: every bit set.
  localparam logic [DIV_WIDTH-1:0] DIVZ_QUOTIENT = '1;

  // Result packing: hi (remainder) above lo (quotient).
  localparam int RES_LO_LSB = 0;
  localparam int RES_HI_LSB = DIV_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DIV  = 2'b01,
    S_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_seq_ctrl_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference if it fits.
// Ports: rem/dividend_msb/divisor in; rem_next and quotient bit out (combinational).
module div_step
  import div_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem, dividend_msb};
  assign diff    = shifted - {1'b0, divisor};

  // rem < divisor on entry, so shifted < 2*divisor and the difference always
  // fits in WIDTH+1 bits; its MSB is therefore a clean borrow flag.
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV/DIVU sequencer for the Execute stage: restoring divider,
// pipeline stall while busy, and a registered {remainder, quotient} result.
// Ports: clk/rst; start/signed_div/opa/opb/cancel in; stall/ready/busy/result out.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic               cancel,
  output logic               stall,
  output logic               ready,
  output logic               busy,
  output logic [2*WIDTH-1:0] result
);

  localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  div_state_e state_q, state_d;

  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] dq;        // dividend bits shift out of the top, quotient bits in at the bottom
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic             neg_q;
  logic             neg_r;

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] dq_next;
  logic [WIDTH-1:0] fix_q;
  logic [WIDTH-1:0] fix_r;

  logic load_start;
  logic load_divz;
  logic do_step;
  logic finish;

  // Operand magnitudes; the most-negative value maps onto itself, which the
  // unsigned datapath reads correctly as 2^(WIDTH-1).
  assign neg_a = signed_div & opa[WIDTH-1];
  assign neg_b = signed_div & opb[WIDTH-1];
  assign abs_a = neg_a ? -opa : opa;
  assign abs_b = neg_b ? -opb : opb;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem          (rem),
    .dividend_msb (dq[WIDTH-1]),
    .divisor      (divisor),
    .rem_next     (rem_next),
    .q_bit        (q_bit)
  );

  assign dq_next = {dq[WIDTH-2:0], q_bit};

  // Sign fix-up on the final step: quotient negative when signs differ,
  // remainder follows the dividend. -2^(W-1) / -1 wraps with no trap.
  assign fix_q = neg_q ? -dq_next  : dq_next;
  assign fix_r = neg_r ? -rem_next : rem_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    busy       = 1'b0;
    load_start = 1'b0;
    load_divz  = 1'b0;
    do_step    = 1'b0;
    finish     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // cancel takes priority: the instruction in E is being flushed
        if (!cancel && start) begin
          if (opb == '0) begin
            load_divz = 1'b1;
            state_d   = S_DONE;
          end else begin
            load_start = 1'b1;
            state_d    = S_DIV;
          end
        end
      end
      S_DIV: begin
        busy = 1'b1;
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          do_step = 1'b1;
          if (count == LAST) begin
            finish  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // result is already committed, so cancel here cannot suppress ready
        busy    = 1'b1;
        ready   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign stall = start & ~ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      dq      <= '0;
      divisor <= '0;
      rem     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= '0;
    end else begin
      if (load_start) begin
        dq      <= abs_a;
        divisor <= abs_b;
        rem     <= '0;
        count   <= '0;
        neg_q   <= neg_a ^ neg_b;
        neg_r   <= neg_a;
      end
      if (load_divz) begin
        result <= {opa, {WIDTH{1'b1}}};
      end
      if (do_step) begin
        rem   <= rem_next;
        dq    <= dq_next;
        count <= count + CNT_W'(1);
      end
      if (finish) begin
        result <= {fix_r, fix_q};
      end
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed self-checking bench for div_seq_ctrl: latency, stall/ready/busy
// handshake, signed/unsigned results, divide-by-zero, cancel and reset.
// Ports: none (top-level bench).
module tb_div_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        cancel;
  logic        stall;
  logic        ready;
  logic        busy;
  logic [63:0] result;

  int total = 0;
  int bad   = 0;

  div_seq_ctrl #(
    .WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opa        (opa),
    .opb        (opb),
    .cancel     (cancel),
    .stall      (stall),
    .ready      (ready),
    .busy       (busy),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues a divide from IDLE with start held, perturbs the operands mid-run
  // (they must not be re-sampled), then checks latency, handshake and result.
  // Leaves start high so the caller can chain a back-to-back divide.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int exp_cyc, input logic [63:0] exp_res);
    int   cyc;
    logic stall_ok;
    signed_div = sgn;
    opa        = a;
    opb        = b;
    start      = 1'b1;
    #1;
    stall_ok = 1'b1;
    cyc      = 0;
    while (ready !== 1'b1 && cyc < 100) begin
      if (stall !== 1'b1) stall_ok = 1'b0;
      tick();
      cyc++;
      if (cyc == 5) begin
        opa = ~a;
        opb = b + 32'd1;
      end
    end
    check({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_stall_held"}, {63'd0, stall_ok}, 64'd1);
    check({tag, "_stall_drop"}, {63'd0, stall}, 64'd0);
    check({tag, "_busy_done"}, {63'd0, busy}, 64'd1);
    check({tag, "_result"}, result, exp_res);
    tick();
    check({tag, "_ready_pulse"}, {63'd0, ready}, 64'd0);
    check({tag, "_busy_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic ready_seen;

    rst        = 1'b1;
    start      = 1'b0;
    signed_div = 1'b0;
    opa        = '0;
    opb        = '0;
    cancel     = 1'b0;
    tick();
    tick();
    check("rst_result", result, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    rst = 1'b0;
    tick();

    // 1: DIVU 100 / 7 -> q=14, r=2
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});
    start = 1'b0;

    // 2: signed -7 / 2 -> q=-3, r=-1 ; 7 / -2 -> q=-3, r=1
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    start = 1'b0;
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'h0000_0001, 32'hFFFF_FFFD});
    start = 1'b0;

    // 3: overflow -2^31 / -1 wraps
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0000_0000, 32'h8000_0000});
    start = 1'b0;

    // 4: divide by zero completes in one cycle
    run_div("divz", 1'b0, 32'h0000_1234, 32'd0, 1, {32'h0000_1234, 32'hFFFF_FFFF});
    start = 1'b0;

    // cancel beats start while idle
    start      = 1'b1;
    cancel     = 1'b1;
    signed_div = 1'b0;
    opa        = 32'd50;
    opb        = 32'd5;
    tick();
    check("idle_cancel_busy", {63'd0, busy}, 64'd0);
    tick();
    check("idle_cancel_ready", {63'd0, ready}, 64'd0);
    start  = 1'b0;
    cancel = 1'b0;
    tick();

    // 5: cancel around iteration 10, result must keep the divide-by-zero value
    signed_div = 1'b0;
    opa        = 32'd1000;
    opb        = 32'd10;
    start      = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    check("cancel_busy_before", {63'd0, busy}, 64'd1);
    cancel = 1'b1;
    start  = 1'b0;
    tick();
    check("cancel_busy", {63'd0, busy}, 64'd0);
    check("cancel_result", result, {32'h0000_1234, 32'hFFFF_FFFF});
    cancel     = 1'b0;
    ready_seen = ready;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready === 1'b1) ready_seen = 1'b1;
    end
    check("cancel_no_ready", {63'd0, ready_seen}, 64'd0);
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 33, {32'd0, 32'd3});
    start = 1'b0;

    // 6: synchronous reset around iteration 20
    signed_div = 1'b0;
    opa        = 32'd100;
    opb        = 32'd7;
    start      = 1'b1;
    for (int i = 0; i < 21; i++) tick();
    rst   = 1'b1;
    start = 1'b0;
    tick();
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_ready", {63'd0, ready}, 64'd0);
    check("midrst_result", result, 64'd0);
    rst = 1'b0;
    tick();

    // back-to-back: start stays high into the idle cycle after ready
    run_div("b2b_first", 1'b1, 32'hFFFF_FF9C, 32'd7, 33, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    run_div("b2b_second", 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 33, {32'h0000_000F, 32'h0FFF_FFFF});
    start = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
